counter_scheduler: RTL and testbench
====================================

COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-high.
REQ-002 Port clk, input, 1 bit: clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-004 Port req0 / req1, input, 1 bit each: job request from requester 0 / 1.
REQ-005 Port dir0 / dir1, input, 1 bit each: count direction; 1 = up, 0 = down.
REQ-006 Port len0 / len1, input, 4 bits each: number of count steps, 0-15.
REQ-007 Port gnt0 / gnt1, output reg, 1 bit each: one-cycle acceptance pulse to requester 0 / 1.
REQ-008 Port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 Port done, output reg, 1 bit: one-cycle job-completion pulse.
REQ-010 Port done_id, output reg, 1 bit: index of the requester whose job completed; valid while done=1.
REQ-011 Port out, output reg, 4 bits: value of the shared up/down counter.
REQ-012 Port wrap, output reg, 1 bit: one-cycle pulse when a counter step wraps.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE with at least one req high, the block SHALL accept one job at the clock edge and go to RUN.
- Acceptance latches dir, len and id into internal registers.
- The accepted requester's gnt SHALL be high for exactly the following cycle.
REQ-015 Arbitration SHALL be round-robin.
- If only one req is high, that requester wins.
- If both are high, the requester not granted last time wins.
- last_id SHALL update on every acceptance.
REQ-016 Requesters SHALL hold req, dir and len stable until they see their gnt, then deassert req in the gnt cycle.
- req, dir and len are ignored outside IDLE.
REQ-017 Requests SHALL NOT be accepted in RUN or DONE.
REQ-018 In RUN, each clock edge SHALL step out by one in the latched direction and decrement the remaining count.
- When a step is taken with remaining=1, the FSM SHALL go to DONE.
REQ-019 Wrap-around rules:
- Up from 15 SHALL give 0.
- Down from 0 SHALL give 15.
- Either case SHALL set wrap=1 for the cycle after that step; otherwise wrap=0.
REQ-020 Timing for a job with len=N≥1 accepted at edge E0:
- out changes at edges E1..EN.
- done=1 and done_id=id during the cycle after EN.
- State is IDLE after edge EN+1.
- The earliest next acceptance is at edge EN+2.
REQ-021 For a job with len=0, the FSM SHALL go from RUN to DONE at E1 without stepping out.
- done pulses in the cycle after E1.
- wrap stays 0.
REQ-022 out SHALL hold its value in IDLE and DONE and SHALL persist across jobs; it is NOT cleared per job.
REQ-023 gnt0 and gnt1 SHALL never be high together; done SHALL never be high for two consecutive cycles.

Reset
REQ-024 While reset=1, the block SHALL asynchronously force all of the following:
- state=IDLE, out=0, remaining=0, last_id=1.
- gnt0=gnt1=0, done=0, done_id=0, wrap=0.
REQ-025 Reset asserted mid-RUN SHALL abort the job with no done pulse.
- After reset deasserts, the first edge with a request SHALL arbitrate from last_id=1, so req0 wins a tie.
REQ-026 Outputs SHALL be free of X from the first reset assertion onward.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Reset, then req0 with dir0=1, len0=3 -> gnt0 pulses one cycle; out goes 1,2,3; done=1 with done_id=0; busy low afterward.
- out=14, then req1 with dir1=1, len1=4 -> out goes 15,0,1,2; wrap pulses once, one cycle after the 15->0 step; done_id=1.
- out=1, then req0 with dir0=0, len0=3 -> out goes 0,15,14; wrap pulses once.
- req0 and req1 both held high over three back-to-back jobs -> grant order is 0,1,0; each next gnt appears two edges after the prior done.
- req1 with len1=0 -> gnt1 pulses, out unchanged, done pulses with done_id=1, wrap=0.
- reset asserted during RUN after 2 of 5 steps -> out=0 immediately; no done pulse; the next tie is granted to req0.

Source files
------------

// File: rtl/counter_scheduler.sv
// Round-robin scheduler for two requesters sharing one 4-bit up/down counter; a job of len N
// holds the counter for N stepping cycles plus one done cycle, and requests wait (req held) while busy.
module counter_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       dir0,
    input  logic       dir1,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic [3:0] out,
    output logic       wrap
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] out_q, out_d;
    logic [3:0] rem_q, rem_d;
    logic       dir_q, dir_d;
    logic       id_q, id_d;
    logic       last_id_q, last_id_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       done_q, done_d;
    logic       done_id_q, done_id_d;
    logic       wrap_q, wrap_d;
    logic       win_id;

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        wrap_d    = 1'b0;
        // on a tie the requester not served last time wins
        win_id    = (req0 && req1) ? ~last_id_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d   = RUN;
                    dir_d     = win_id ? dir1 : dir0;
                    rem_d     = win_id ? len1 : len0;
                    id_d      = win_id;
                    last_id_d = win_id;
                    gnt0_d    = ~win_id;
                    gnt1_d    = win_id;
                end
            end
            RUN: begin
                if (rem_q != 4'd0) begin
                    out_d  = dir_q ? out_q + 4'd1 : out_q - 4'd1;
                    wrap_d = dir_q ? (out_q == 4'd15) : (out_q == 4'd0);
                    rem_d  = rem_q - 4'd1;
                end
                // len=0 jobs finish here too, without touching the counter
                if (rem_q <= 4'd1) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            out_q     <= 4'd0;
            rem_q     <= 4'd0;
            dir_q     <= 1'b0;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            rem_q     <= rem_d;
            dir_q     <= dir_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            wrap_q    <= wrap_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign done_id = done_id_q;
    assign out     = out_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler: inputs driven and outputs sampled on the falling edge.
module tb_counter_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, dir0, dir1;
    logic [3:0] len0, len1;
    logic       gnt0, gnt1, busy, done, done_id, wrap;
    logic [3:0] out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    counter_scheduler dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .dir0    (dir0),
        .dir1    (dir1),
        .len0    (len0),
        .len1    (len1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .out     (out),
        .wrap    (wrap)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // drives one request through its acceptance edge, then drops req
    task automatic start_job(input logic id, input logic d, input logic [3:0] l);
        if (id) begin
            req1 = 1'b1; dir1 = d; len1 = l;
        end else begin
            req0 = 1'b1; dir0 = d; len0 = l;
        end
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, busy, done, done_id, wrap, out} !== 10'd0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", {gnt0, gnt1, busy, done, done_id, wrap, out}, 10'd0);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || out !== 4'd0) begin
            failures++;
            $display("FAIL reset_idle busy=%b out=%0d exp busy=0 out=0", busy, out);
        end
    endtask

    task automatic test_up_count;
        start_job(1'b0, 1'b1, 4'd3);
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b1 || out !== 4'd0) begin
            failures++;
            $display("FAIL up_grant gnt0=%b gnt1=%b busy=%b out=%0d exp 1 0 1 0", gnt0, gnt1, busy, out);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (out !== 4'(i) || gnt0 !== 1'b0 || wrap !== 1'b0) begin
                failures++;
                $display("FAIL up_step%0d out=%0d gnt0=%b wrap=%b exp out=%0d gnt0=0 wrap=0", i, out, gnt0, wrap, i);
            end
            checks++;
            if (done !== (i == 3)) begin
                failures++;
                $display("FAIL up_done%0d got=%b exp=%b", i, done, (i == 3));
            end
        end
        checks++;
        if (done_id !== 1'b0) begin
            failures++;
            $display("FAIL up_done_id got=%b exp=0", done_id);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 4'd3) begin
            failures++;
            $display("FAIL up_after busy=%b done=%b out=%0d exp 0 0 3", busy, done, out);
        end
    endtask

    task automatic test_wrap_up;
        logic [3:0] exp_o [4];
        logic       exp_w [4];
        exp_o = '{4'd15, 4'd0, 4'd1, 4'd2};
        exp_w = '{1'b0, 1'b1, 1'b0, 1'b0};
        start_job(1'b0, 1'b1, 4'd11);
        repeat (12) tick();
        checks++;
        if (out !== 4'd14 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wrap_up_setup out=%0d busy=%b exp 14 0", out, busy);
        end
        start_job(1'b1, 1'b1, 4'd4);
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            failures++;
            $display("FAIL wrap_up_grant gnt0=%b gnt1=%b exp 0 1", gnt0, gnt1);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out !== exp_o[i] || wrap !== exp_w[i]) begin
                failures++;
                $display("FAIL wrap_up_step%0d out=%0d wrap=%b exp out=%0d wrap=%b", i, out, wrap, exp_o[i], exp_w[i]);
            end
        end
        checks++;
        if (done !== 1'b1 || done_id !== 1'b1) begin
            failures++;
            $display("FAIL wrap_up_done done=%b id=%b exp 1 1", done, done_id);
        end
        tick();
    endtask

    task automatic test_wrap_down;
        logic [3:0] exp_o [3];
        logic       exp_w [3];
        exp_o = '{4'd0, 4'd15, 4'd14};
        exp_w = '{1'b0, 1'b1, 1'b0};
        start_job(1'b0, 1'b0, 4'd1);
        repeat (2) tick();
        checks++;
        if (out !== 4'd1) begin
            failures++;
            $display("FAIL wrap_down_setup out=%0d exp=1", out);
        end
        start_job(1'b0, 1'b0, 4'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out !== exp_o[i] || wrap !== exp_w[i]) begin
                failures++;
                $display("FAIL wrap_down_step%0d out=%0d wrap=%b exp out=%0d wrap=%b", i, out, wrap, exp_o[i], exp_w[i]);
            end
        end
        checks++;
        if (done !== 1'b1 || done_id !== 1'b0) begin
            failures++;
            $display("FAIL wrap_down_done done=%b id=%b exp 1 0", done, done_id);
        end
        tick();
        checks++;
        if (wrap !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wrap_down_after wrap=%b busy=%b exp 0 0", wrap, busy);
        end
    endtask

    task automatic test_back_to_back;
        int   ngnt      = 0;
        int   last_done = -100;
        logic prev_done = 1'b0;
        logic order [3];
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        dir0 = 1'b1; dir1 = 1'b1;
        len0 = 4'd1; len1 = 4'd1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            tick();
            if (gnt0 && gnt1) begin
                checks++;
                failures++;
                $display("FAIL b2b_both_gnt cycle=%0d gnt0=1 gnt1=1 exp at most one", cyc);
            end
            if (done) begin
                checks++;
                if (prev_done !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_done_twice cycle=%0d got consecutive done exp single", cyc);
                end
                last_done = cyc;
            end
            if ((gnt0 || gnt1) && ngnt < 3) begin
                order[ngnt] = gnt1;
                if (ngnt > 0) begin
                    checks++;
                    if (cyc - last_done !== 2) begin
                        failures++;
                        $display("FAIL b2b_gap%0d got=%0d exp=2", ngnt, cyc - last_done);
                    end
                end
                ngnt++;
                if (ngnt == 3) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
            prev_done = done;
        end
        checks++;
        if (ngnt !== 3 || order[0] !== 1'b0 || order[1] !== 1'b1 || order[2] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_order count=%0d order=%b%b%b exp count=3 order=010", ngnt, order[0], order[1], order[2]);
        end
        checks++;
        if (out !== 4'd3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_final out=%0d busy=%b exp 3 0", out, busy);
        end
    endtask

    task automatic test_len_zero;
        start_job(1'b1, 1'b1, 4'd0);
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || out !== 4'd3) begin
            failures++;
            $display("FAIL len0_grant gnt0=%b gnt1=%b out=%0d exp 0 1 3", gnt0, gnt1, out);
        end
        tick();
        checks++;
        if (done !== 1'b1 || done_id !== 1'b1 || wrap !== 1'b0 || out !== 4'd3) begin
            failures++;
            $display("FAIL len0_done done=%b id=%b wrap=%b out=%0d exp 1 1 0 3", done, done_id, wrap, out);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out !== 4'd3) begin
            failures++;
            $display("FAIL len0_after done=%b busy=%b out=%0d exp 0 0 3", done, busy, out);
        end
    endtask

    task automatic test_reset_mid_run;
        start_job(1'b0, 1'b1, 4'd5);
        tick();
        tick();
        checks++;
        if (out !== 4'd5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_setup out=%0d busy=%b exp 5 1", out, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_async out=%0d busy=%b done=%b exp 0 0 0", out, busy, done);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done done=%b busy=%b exp 0 0", done, busy);
        end
        req0 = 1'b1; req1 = 1'b1;
        dir0 = 1'b1; dir1 = 1'b1;
        len0 = 4'd1; len1 = 4'd1;
        tick();
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL abort_tie gnt0=%b gnt1=%b exp 1 0", gnt0, gnt1);
        end
        tick();
        checks++;
        if (done !== 1'b1 || done_id !== 1'b0 || out !== 4'd1) begin
            failures++;
            $display("FAIL abort_next_job done=%b id=%b out=%0d exp 1 0 1", done, done_id, out);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        dir0 = 1'b0; dir1 = 1'b0;
        len0 = 4'd0; len1 = 4'd0;
        test_reset();
        test_up_count();
        test_wrap_up();
        test_wrap_down();
        test_back_to_back();
        test_len_zero();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
